// File: rtl/ita_div_scheduler.sv
// Issues softmax dividends to a pool of iterative dividers and returns results in order.
// Optional protocol checking and the sticky err_o flag: define ITA_DIV_SCHED_CHECK_EN.
module ita_div_scheduler #(
  parameter int unsigned NumDiv   = 4,
  parameter int unsigned InWidth  = 19,
  parameter int unsigned OutWidth = 24,
  parameter int unsigned RowLen   = 64,
  localparam int unsigned TagW    = $clog2(NumDiv),
  localparam int unsigned AddrW   = $clog2(RowLen),
  localparam int unsigned OccW    = TagW + 1
) (
  input  logic                               clk_i,
  input  logic                               rst_i,
  input  logic                               in_valid_i,
  output logic                               in_ready_o,
  input  logic [InWidth-1:0]                 in_data_i,
  output logic [InWidth-1:0]                 div_inp_o,
  output logic [NumDiv-1:0]                  div_valid_o,
  input  logic [NumDiv-1:0]                  div_ready_i,
  input  logic [NumDiv-1:0]                  div_valid_i,
  output logic [NumDiv-1:0]                  div_ready_o,
  input  logic [NumDiv-1:0][OutWidth-1:0]    div_oup_i,
  output logic                               out_valid_o,
  input  logic                               out_ready_i,
  output logic [OutWidth-1:0]                out_data_o,
  output logic [AddrW-1:0]                   out_addr_o,
  output logic                               row_done_o,
  output logic [OccW-1:0]                    pending_o,
  output logic                               err_o
);

  logic [NumDiv-1:0]   busy_q, busy_d;
  logic [NumDiv-1:0]   rob_vld_q, rob_vld_d;
  logic [TagW-1:0]     tag_q [NumDiv];
  logic [OutWidth-1:0] rob_data_q [NumDiv];
  logic [TagW-1:0]     tail_q, head_q;
  logic [AddrW-1:0]    addr_q;
  logic [OccW-1:0]     occ_q;

  logic [TagW-1:0]     sel;
  logic [NumDiv-1:0]   sel_oh;
  logic                any_idle;
  logic                can_issue;
  logic                issue;
  logic                retire;
  logic [NumDiv-1:0]   complete;

  // Lowest-index idle divider, from registered busy only.
  always_comb begin
    sel      = '0;
    sel_oh   = '0;
    any_idle = 1'b0;
    for (int i = int'(NumDiv) - 1; i >= 0; i--) begin
      if (!busy_q[i]) begin
        sel      = TagW'(i);
        any_idle = 1'b1;
      end
    end
    sel_oh[sel] = any_idle;
  end

  assign can_issue   = any_idle && (occ_q < OccW'(NumDiv)) && !rst_i;
  assign div_valid_o = (in_valid_i && can_issue) ? sel_oh : '0;
  assign div_inp_o   = in_data_i;
  assign in_ready_o  = can_issue && div_ready_i[sel];
  assign issue       = in_valid_i && in_ready_o;

  assign div_ready_o = rst_i ? '0 : busy_q;
  assign complete    = div_valid_i & busy_q;

  assign out_valid_o = rob_vld_q[head_q] && !rst_i;
  assign out_data_o  = rob_data_q[head_q];
  assign out_addr_o  = addr_q;
  assign retire      = out_valid_o && out_ready_i;
  assign row_done_o  = retire && (addr_q == AddrW'(RowLen - 1));
  assign pending_o   = occ_q;

  always_comb begin
    busy_d    = (busy_q & ~complete) | (issue ? sel_oh : '0);
    rob_vld_d = rob_vld_q;
    if (retire) rob_vld_d[head_q] = 1'b0;
    for (int k = 0; k < int'(NumDiv); k++) begin
      if (complete[k]) rob_vld_d[tag_q[k]] = 1'b1;
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      busy_q    <= '0;
      rob_vld_q <= '0;
      tail_q    <= '0;
      head_q    <= '0;
      addr_q    <= '0;
      occ_q     <= '0;
    end else begin
      busy_q    <= busy_d;
      rob_vld_q <= rob_vld_d;
      occ_q     <= occ_q + OccW'(issue) - OccW'(retire);
      if (issue) tail_q <= tail_q + 1'b1;
      if (retire) begin
        head_q <= head_q + 1'b1;
        addr_q <= addr_q + 1'b1;
      end
    end
  end

  // Payload storage needs no reset; validity lives in busy_q/rob_vld_q.
  always_ff @(posedge clk_i) begin
    if (issue) tag_q[sel] <= tail_q;
    for (int k = 0; k < int'(NumDiv); k++) begin
      if (complete[k]) rob_data_q[tag_q[k]] <= div_oup_i[k];
    end
  end

`ifdef ITA_DIV_SCHED_CHECK_EN
  logic err_q;
  logic viol;

  always_comb begin
    viol = 1'b0;
    for (int k = 0; k < int'(NumDiv); k++) begin
      if (div_valid_i[k] && !busy_q[k]) viol = 1'b1;
      if (complete[k] && rob_vld_q[tag_q[k]]) viol = 1'b1;
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) err_q <= 1'b0;
    else if (viol) err_q <= 1'b1;
  end

  assign err_o = err_q;

  always_ff @(posedge clk_i) begin
    if (!rst_i) begin
      assert (!viol)
        else $warning("divider result protocol violation");
      assert ($onehot0(div_valid_o))
        else $error("div_valid_o not one-hot");
    end
  end
`else
  assign err_o = 1'b0;
`endif

endmodule
